wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage, directly downstream of the MEM/WB pipeline register; consumes its latched outputs.
- Selects and extends register-file write data and drives the GPR write port.
- Owns the HI/LO special registers and the syscall halt/display state machine.
- Counts retired instructions and drives the global pipeline-advance enable while halted.

Parameters:
- DATA_BITS, 32, datapath width
- PC_BITS, 32, PC width
- HALT_CODE, 32'd10, $v0 value that makes a syscall halt
- CNT_BITS, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pc_in  in  PC_BITS  address of the instruction in WB
- ir_in  in  32  instruction word; all-zero means bubble (invalid)
- write_in  in  6  destination register; bits [4:0] used
- reg_write_in  in  1  GPR write enable
- mem_to_reg_in  in  1  select memory data
- jal_in  in  1  write pc_in+4
- extr_word_in  in  2  00 word, 01 byte, 10 halfword, 11 treated as word
- extr_signed_in  in  1  1 sign-extend, 0 zero-extend
- to_lh_in  in  1  write HI/LO
- lh_to_reg_in  in  2  01 select LO, 10 select HI
- cp0_to_reg_in  in  1  select cp0_in
- alu_in, alu2_in, mem_in, cp0_in  in  DATA_BITS  result operands
- syscall_in  in  1  syscall in WB
- v0_in, a0_in  in  DATA_BITS  current $v0 / $a0 values
- go  in  1  resume pulse from board
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  DATA_BITS  GPR write data
- hi, lo  out  DATA_BITS  special registers
- disp_data  out  DATA_BITS  last syscall display value
- halted  out  1  FSM in HALT
- pipe_en  out  1  pipeline advance enable (1 = advance)
- retired  out  CNT_BITS  retired-instruction count

Behaviour:
- Reset (async, rst=1): hi=lo=0, disp_data=0, retired=0, state=RUN.
- Reset mid-HALT returns to RUN immediately.
- valid = |ir_in.
- rf_wdata (combinational), priority order:
  - jal_in: pc_in+4
  - cp0_to_reg_in: cp0_in
  - lh_to_reg_in=01: lo; =10: hi (registered values)
  - mem_to_reg_in: extracted memory data
  - otherwise: alu_in
- Memory extraction:
  - byte: lane mem_in[8*alu_in[1:0] +: 8]
  - halfword: lane mem_in[16*alu_in[1] +: 16]
  - extension per extr_signed_in
  - word: mem_in unchanged
- rf_we = reg_write_in & valid & (write_in[4:0]≠0) & state==RUN. rf_waddr = write_in[4:0].
- HI/LO:
  - When to_lh_in & valid & RUN: lo<=alu_in, hi<=alu2_in at the edge.
  - mfhi/mflo in the same cycle read the old value; no internal bypass.
- FSM states RUN, HALT:
  - RUN, syscall_in & valid, v0_in==HALT_CODE: go to HALT next edge.
  - RUN, syscall_in & valid, v0_in≠HALT_CODE: disp_data<=a0_in; stay RUN.
  - HALT: rf_we=0, HI/LO frozen, retired frozen, pipe_en=0.
  - HALT & go: back to RUN. go in RUN is ignored.
- pipe_en = (state==RUN). halted = (state==HALT).
- retired: +1 per edge when valid & RUN, including the halting syscall itself; wraps modulo 2^CNT_BITS.
- Simultaneous to_lh and lh_to_reg do not occur by decode; if both are set, HI/LO are still written and rf_wdata uses the old value.

Decomposition:
- Shared package cpu_pkg:
  - EXTR_WORD/EXTR_BYTE/EXTR_HALF encodings
  - LH_LO/LH_HI encodings
  - HALT_CODE
  - state enum {RUN, HALT}
- One sub-module, mem_extract: combinational lane select and extension, reusable by the forwarding path.

Test Plan:
- lb: mem_in=32'h80FF7F01, alu_in[1:0]=2 -> rf_wdata=32'hFFFFFFFF. lbu -> 32'h000000FF. lh, alu_in[1]=1 -> 32'hFFFF80FF.
- mult write then mflo: to_lh with alu_in=5, alu2_in=7 -> next cycle lo=5, hi=7; lh_to_reg=10 -> rf_wdata=7.
- Write to $0: reg_write=1, write_in=0 -> rf_we=0. jal at pc_in=32'h3000 -> rf_wdata=32'h3004, rf_waddr=31.
- Syscall v0=1, a0=42 -> disp_data=42, still RUN. Syscall v0=10 -> halted=1, pipe_en=0, retired frozen. go -> RUN.
- Retire counting: 5 valid instructions + 2 bubbles -> retired=5. Preloaded 32'hFFFFFFFF + 1 valid -> 0.
- Async rst asserted between edges while HALT -> halted=0, hi=lo=disp_data=retired=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the write-back datapath and syscall control.
// Pure declarations; no logic.
package cpu_pkg;

  localparam logic [1:0] EXTR_WORD = 2'b00;
  localparam logic [1:0] EXTR_BYTE = 2'b01;
  localparam logic [1:0] EXTR_HALF = 2'b10;

  localparam logic [1:0] LH_LO = 2'b01;
  localparam logic [1:0] LH_HI = 2'b10;

  localparam logic [31:0] HALT_CODE = 32'd10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_mem_extract.sv
// Load-data lane select and sign/zero extension for lb/lbu/lh/lhu/lw.
// Combinational, zero latency; no flow control.
module mem_extract
  import cpu_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] mem_data,
  input  logic [1:0]           addr_lo,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  output logic [DATA_BITS-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_data[{addr_lo, 3'b000} +: 8];
    half_lane = mem_data[{addr_lo[1], 4'b0000} +: 16];
    data      = mem_data;
    case (extr_word)
      EXTR_BYTE: data = {{(DATA_BITS-8){extr_signed & byte_lane[7]}}, byte_lane};
      EXTR_HALF: data = {{(DATA_BITS-16){extr_signed & half_lane[15]}}, half_lane};
      default:   data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: GPR write port, HI/LO, syscall halt/display FSM, retire counter.
// Write data is combinational from MEM/WB; state updates at the edge; halt stalls via pipe_en.
module wb_stage #(
  parameter int                   DATA_BITS = 32,
  parameter int                   PC_BITS   = 32,
  parameter logic [DATA_BITS-1:0] HALT_CODE = DATA_BITS'(cpu_pkg::HALT_CODE),
  parameter int                   CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_BITS-1:0]   pc_in,
  input  logic [31:0]          ir_in,
  input  logic [5:0]           write_in,
  input  logic                 reg_write_in,
  input  logic                 mem_to_reg_in,
  input  logic                 jal_in,
  input  logic [1:0]           extr_word_in,
  input  logic                 extr_signed_in,
  input  logic                 to_lh_in,
  input  logic [1:0]           lh_to_reg_in,
  input  logic                 cp0_to_reg_in,
  input  logic [DATA_BITS-1:0] alu_in,
  input  logic [DATA_BITS-1:0] alu2_in,
  input  logic [DATA_BITS-1:0] mem_in,
  input  logic [DATA_BITS-1:0] cp0_in,
  input  logic                 syscall_in,
  input  logic [DATA_BITS-1:0] v0_in,
  input  logic [DATA_BITS-1:0] a0_in,
  input  logic                 go,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_BITS-1:0] rf_wdata,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo,
  output logic [DATA_BITS-1:0] disp_data,
  output logic                 halted,
  output logic                 pipe_en,
  output logic [CNT_BITS-1:0]  retired
);

  import cpu_pkg::*;

  wb_state_t            state_q, state_d;
  logic                 valid;
  logic                 run;
  logic                 commit;
  logic                 syscall_fire;
  logic                 halt_req;
  logic [DATA_BITS-1:0] mem_ext;
  logic                 unused_write_msb;

  assign unused_write_msb = write_in[5];

  assign valid        = |ir_in;
  assign run          = (state_q == RUN);
  assign commit       = valid & run;
  assign syscall_fire = syscall_in & commit;
  assign halt_req     = syscall_fire & (v0_in == HALT_CODE);

  mem_extract #(.DATA_BITS(DATA_BITS)) u_mem_extract (
    .mem_data    (mem_in),
    .addr_lo     (alu_in[1:0]),
    .extr_word   (extr_word_in),
    .extr_signed (extr_signed_in),
    .data        (mem_ext)
  );

  // HI/LO reads see the registered value; a same-cycle write is not bypassed.
  always_comb begin
    rf_wdata = alu_in;
    if (jal_in)                  rf_wdata = DATA_BITS'(pc_in + PC_BITS'(4));
    else if (cp0_to_reg_in)      rf_wdata = cp0_in;
    else if (lh_to_reg_in == LH_LO) rf_wdata = lo;
    else if (lh_to_reg_in == LH_HI) rf_wdata = hi;
    else if (mem_to_reg_in)      rf_wdata = mem_ext;
  end

  assign rf_waddr = write_in[4:0];
  assign rf_we    = reg_write_in & commit & (write_in[4:0] != 5'd0);
  assign halted   = (state_q == HALT);
  assign pipe_en  = run;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (go)       state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      disp_data <= '0;
      retired   <= '0;
    end else if (commit) begin
      retired <= retired + CNT_BITS'(1);
      if (to_lh_in) begin
        lo <= alu_in;
        hi <= alu2_in;
      end
      if (syscall_fire && !halt_req) disp_data <= a0_in;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed checks of wb_stage against a behavioural model.
module tb_wb_stage;

  localparam int DB = 32;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc_in, ir_in, alu_in, alu2_in, mem_in, cp0_in, v0_in, a0_in;
  logic [5:0]    write_in;
  logic          reg_write_in, mem_to_reg_in, jal_in, extr_signed_in, to_lh_in;
  logic          cp0_to_reg_in, syscall_in, go;
  logic [1:0]    extr_word_in, lh_to_reg_in;
  logic          rf_we, halted, pipe_en;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata, hi, lo, disp_data;
  logic [CB-1:0] retired;

  int checks = 0;
  int failures = 0;

  wb_stage #(.DATA_BITS(DB), .PC_BITS(32), .HALT_CODE(32'd10), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ir_in(ir_in), .write_in(write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .jal_in(jal_in),
    .extr_word_in(extr_word_in), .extr_signed_in(extr_signed_in), .to_lh_in(to_lh_in),
    .lh_to_reg_in(lh_to_reg_in), .cp0_to_reg_in(cp0_to_reg_in), .alu_in(alu_in),
    .alu2_in(alu2_in), .mem_in(mem_in), .cp0_in(cp0_in), .syscall_in(syscall_in),
    .v0_in(v0_in), .a0_in(a0_in), .go(go), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .hi(hi), .lo(lo), .disp_data(disp_data), .halted(halted),
    .pipe_en(pipe_en), .retired(retired)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_hi = 0, m_lo = 0, m_disp = 0;
  int          m_ret = 0;
  bit          m_halt = 0;

  function automatic logic [31:0] model_load(logic [31:0] mem, logic [31:0] addr,
                                             logic [1:0] kind, logic sgn);
    logic [31:0] v;
    if (kind == 2'd1) begin
      v = (mem >> (8 * addr[1:0])) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (kind == 2'd2) begin
      v = (mem >> (16 * addr[1])) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata();
    if (jal_in)                   return pc_in + 32'd4;
    if (cp0_to_reg_in)            return cp0_in;
    if (lh_to_reg_in == 2'b01)    return m_lo;
    if (lh_to_reg_in == 2'b10)    return m_hi;
    if (mem_to_reg_in)            return model_load(mem_in, alu_in, extr_word_in, extr_signed_in);
    return alu_in;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_disp = 0; m_ret = 0; m_halt = 0;
    end else if (m_halt) begin
      if (go) m_halt = 0;
    end else if (ir_in != 0) begin
      m_ret = (m_ret + 1) % (1 << CB);
      if (to_lh_in) begin
        m_lo = alu_in;
        m_hi = alu2_in;
      end
      if (syscall_in) begin
        if (v0_in == 32'd10) m_halt = 1;
        else                 m_disp = a0_in;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous compare against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rf_we", 32'(rf_we), 32'(((ir_in != 0) && reg_write_in && (write_in[4:0] != 0) && !m_halt)));
      chk("m_rf_waddr", 32'(rf_waddr), 32'(write_in[4:0]));
      chk("m_rf_wdata", rf_wdata, model_wdata());
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
      chk("m_disp", disp_data, m_disp);
      chk("m_halted", 32'(halted), 32'(m_halt));
      chk("m_pipe_en", 32'(pipe_en), 32'(!m_halt));
      chk("m_retired", 32'(retired), 32'(m_ret));
    end
  end

  task automatic nop();
    pc_in = 0; ir_in = 0; alu_in = 0; alu2_in = 0; mem_in = 0; cp0_in = 0;
    v0_in = 0; a0_in = 0; write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    jal_in = 0; extr_signed_in = 0; to_lh_in = 0; cp0_to_reg_in = 0;
    syscall_in = 0; go = 0; extr_word_in = 0; lh_to_reg_in = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    nop();
    cyc();
    cyc();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_disp", disp_data, 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pipe_en", 32'(pipe_en), 32'h1);
    rst = 1'b0;

    // Loads
    ir_in = 32'h1; reg_write_in = 1; write_in = 6'd5; mem_to_reg_in = 1;
    mem_in = 32'h80FF7F01; alu_in = 32'd2; extr_word_in = 2'b01; extr_signed_in = 1;
    #1 chk("lb", rf_wdata, 32'hFFFFFFFF);
    extr_signed_in = 0;
    #1 chk("lbu", rf_wdata, 32'h000000FF);
    extr_word_in = 2'b10; extr_signed_in = 1;
    #1 chk("lh", rf_wdata, 32'hFFFF80FF);

    // mult then mflo/mfhi
    cyc();
    nop(); ir_in = 32'h18; to_lh_in = 1; alu_in = 32'd5; alu2_in = 32'd7;
    cyc();
    nop(); ir_in = 32'h10; reg_write_in = 1; write_in = 6'd8; lh_to_reg_in = 2'b10;
    #1 chk("lo_after_mult", lo, 32'd5);
    chk("hi_after_mult", hi, 32'd7);
    chk("mfhi", rf_wdata, 32'd7);

    // $0 write, jal
    cyc();
    nop(); ir_in = 32'h1; reg_write_in = 1; write_in = 6'd0;
    #1 chk("we_r0", 32'(rf_we), 32'h0);
    cyc();
    nop(); ir_in = 32'h0C000000; reg_write_in = 1; write_in = 6'd31; jal_in = 1; pc_in = 32'h3000;
    #1 chk("jal_wdata", rf_wdata, 32'h3004);
    chk("jal_waddr", 32'(rf_waddr), 32'd31);
    chk("jal_we", 32'(rf_we), 32'h1);

    // Syscalls
    cyc();
    nop(); ir_in = 32'hC; syscall_in = 1; v0_in = 32'd1; a0_in = 32'd42;
    cyc();
    nop();
    #1 chk("disp_42", disp_data, 32'd42);
    chk("run_after_print", 32'(halted), 32'h0);
    ir_in = 32'hC; syscall_in = 1; v0_in = 32'd10;
    cyc();
    begin
      logic [CB-1:0] frozen;
      frozen = retired;
      nop(); ir_in = 32'h1; reg_write_in = 1; write_in = 6'd3; to_lh_in = 1; alu_in = 32'd99;
      #1 chk("halted", 32'(halted), 32'h1);
      chk("halt_pipe_en", 32'(pipe_en), 32'h0);
      chk("halt_we", 32'(rf_we), 32'h0);
      cyc(); cyc();
      chk("halt_retired_frozen", 32'(retired), 32'(frozen));
      chk("halt_lo_frozen", lo, 32'd5);
    end
    go = 1;
    cyc();
    nop();
    #1 chk("resume", 32'(halted), 32'h0);

    // Retire counting and wrap
    do_reset();
    for (int i = 0; i < 7; i++) begin
      nop(); ir_in = (i == 2 || i == 5) ? 32'h0 : 32'h1;
      cyc();
    end
    nop();
    chk("retired_5", 32'(retired), 32'd5);
    do_reset();
    ir_in = 32'h1;
    repeat (255) cyc();
    chk("retired_255", 32'(retired), 32'd255);
    cyc();
    nop();
    chk("retired_wrap", 32'(retired), 32'd0);

    // Async reset while halted
    nop(); ir_in = 32'h18; to_lh_in = 1; alu_in = 32'd3; alu2_in = 32'd4;
    cyc();
    nop(); ir_in = 32'hC; syscall_in = 1; v0_in = 32'd10;
    cyc();
    nop();
    #1 chk("pre_rst_halted", 32'(halted), 32'h1);
    #1 rst = 1'b1;
    #1 chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_disp", disp_data, 32'h0);
    chk("arst_retired", 32'(retired), 32'h0);
    cyc();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pc_in = $urandom; alu_in = $urandom; alu2_in = $urandom; mem_in = $urandom;
      cp0_in = $urandom; a0_in = $urandom;
      ir_in = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      write_in = 6'($urandom);
      reg_write_in = 1'($urandom);
      mem_to_reg_in = 1'($urandom);
      jal_in = ($urandom_range(0, 7) == 0);
      cp0_to_reg_in = ($urandom_range(0, 7) == 0);
      extr_word_in = 2'($urandom);
      extr_signed_in = 1'($urandom);
      to_lh_in = ($urandom_range(0, 3) == 0);
      lh_to_reg_in = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      syscall_in = ($urandom_range(0, 15) == 0);
      v0_in = $urandom_range(0, 1) ? 32'd10 : $urandom_range(0, 20);
      go = ($urandom_range(0, 3) == 0);
      cyc();
    end
    nop();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
